// File: rtl/upm_address_decoder_seq.sv
// Registered, handshaked UPM address decoder: accepts an address on valid/ready,
// holds a one-hot select for HOLD_CYCLES, then idles GAP_CYCLES before the next accept.
module upm_address_decoder_seq #(
  parameter int WIDTH       = 4,
  parameter int NUM_OUTPUTS = 2**WIDTH,
  parameter bit ZERO_NULL   = 1'b1,
  parameter int HOLD_CYCLES = 1,
  parameter int GAP_CYCLES  = 0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   req_valid,
  input  logic [WIDTH-1:0]       req_address,
  output logic                   req_ready,
  output logic [NUM_OUTPUTS-1:0] dec_address,
  output logic                   dec_active,
  output logic                   dec_done,
  output logic                   dec_err
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACTIVE = 2'd1;
  localparam logic [1:0] ST_GAP    = 2'd2;

  localparam logic [7:0] HOLD_LOAD = 8'(HOLD_CYCLES - 1);
  localparam logic [7:0] GAP_LOAD  = 8'((GAP_CYCLES > 0) ? (GAP_CYCLES - 1) : 0);
  // One extra bit so that NUM_OUTPUTS == 2**WIDTH does not wrap to zero.
  localparam logic [WIDTH:0] LIMIT = (WIDTH + 1)'(NUM_OUTPUTS);

  logic [1:0]             state_reg;
  logic [1:0]             state_next;
  logic [7:0]             count_reg;
  logic [7:0]             count_next;
  logic [NUM_OUTPUTS-1:0] sel_onehot;
  logic [NUM_OUTPUTS-1:0] dec_address_next;
  logic                   dec_done_next;
  logic                   dec_err_next;
  logic                   accept;
  logic                   addr_in_range;
  logic                   addr_null;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_OUTPUTS; gi++) begin : g_sel
      assign sel_onehot[gi] = (req_address == WIDTH'(gi));
    end
  endgenerate

  assign accept        = req_valid && req_ready;
  assign addr_in_range = ({1'b0, req_address} < LIMIT);
  assign addr_null     = ZERO_NULL && (req_address == '0);

  always_comb begin
    state_next       = state_reg;
    count_next       = count_reg;
    dec_address_next = dec_address;
    dec_done_next    = 1'b0;
    dec_err_next     = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        dec_address_next = '0;
        if (accept) begin
          if (!addr_in_range) begin
            dec_err_next = 1'b1;
          end else if (addr_null) begin
            dec_done_next = 1'b1;
          end else begin
            state_next       = ST_ACTIVE;
            count_next       = HOLD_LOAD;
            dec_address_next = sel_onehot;
          end
        end
      end
      ST_ACTIVE: begin
        if (count_reg != 8'd0) begin
          count_next = count_reg - 8'd1;
        end else begin
          // Dropping the select before returning to IDLE gives break-before-make.
          dec_address_next = '0;
          dec_done_next    = 1'b1;
          if (GAP_CYCLES > 0) begin
            state_next = ST_GAP;
            count_next = GAP_LOAD;
          end else begin
            state_next = ST_IDLE;
          end
        end
      end
      ST_GAP: begin
        if (count_reg != 8'd0) begin
          count_next = count_reg - 8'd1;
        end else begin
          state_next = ST_IDLE;
        end
      end
      default: begin
        state_next       = ST_IDLE;
        dec_address_next = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= ST_IDLE;
      count_reg   <= 8'd0;
      dec_address <= '0;
      dec_active  <= 1'b0;
      dec_done    <= 1'b0;
      dec_err     <= 1'b0;
      req_ready   <= 1'b0;
    end else begin
      state_reg   <= state_next;
      count_reg   <= count_next;
      dec_address <= dec_address_next;
      dec_active  <= |dec_address_next;
      dec_done    <= dec_done_next;
      dec_err     <= dec_err_next;
      req_ready   <= (state_next == ST_IDLE);
    end
  end

endmodule
